// File: rtl/rtc_cmd_ctrl.sv
// Command controller in front of the RTC: round-robin arbitration between the host (A) and the
// servo loop (B), one ld pulse per command, settle wait, then a done/err response.
module rtc_cmd_ctrl #(
    parameter logic [39:0] PERIOD_DEFAULT = 40'h08_0000_0000,
    parameter logic [37:0] MODULO_DEFAULT = 38'd256000000000,
    parameter int          SETTLE_CYC     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [1:0]  a_cmd,
    input  logic [87:0] a_data,
    output logic        a_done,
    output logic        a_err,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [1:0]  b_cmd,
    input  logic [87:0] b_data,
    output logic        b_done,
    output logic        b_err,
    output logic        busy,
    output logic        time_ld,
    output logic [37:0] time_reg_ns_in,
    output logic [47:0] time_reg_sec_in,
    output logic        period_ld,
    output logic [39:0] period_in,
    output logic        adj_ld,
    output logic [31:0] adj_ld_data,
    output logic [39:0] period_adj,
    output logic [37:0] time_acc_modulo
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [1:0]  CMD_TIME   = 2'd0;
    localparam logic [1:0]  CMD_PERIOD = 2'd1;
    localparam logic [1:0]  CMD_ADJ    = 2'd2;
    localparam logic [1:0]  CMD_MODULO = 2'd3;
    localparam logic [33:0] SETTLE     = 34'(SETTLE_CYC);
    localparam logic [31:0] CNT_IDLE   = 32'hFFFF_FFFF;

    state_t      state_reg, state_next;
    logic        init_ld_reg, init_ld_next;
    logic        rr_b_reg, rr_b_next;
    logic        port_b_reg, port_b_next;
    logic [1:0]  cmd_reg, cmd_next;
    logic        err_reg, err_next;
    logic [33:0] wait_cnt_reg, wait_cnt_next;
    logic [37:0] modulo_pend_reg, modulo_pend_next;
    logic [37:0] ns_reg, ns_next;
    logic [47:0] sec_reg, sec_next;
    logic [39:0] period_in_reg, period_in_next;
    logic [31:0] adj_data_reg, adj_data_next;
    logic [39:0] period_adj_reg, period_adj_next;
    logic [37:0] modulo_reg, modulo_next;

    // Per-port request/response vectors: index 0 is port A, index 1 is port B.
    logic [1:0]  valid_vec;
    logic [1:0]  grant_vec;
    logic [1:0]  ready_vec;
    logic [1:0]  done_vec;
    logic [1:0]  err_vec;
    logic [1:0]  cmd_vec  [2];
    logic [87:0] data_vec [2];

    logic        sel_b;
    logic        accept;
    logic [1:0]  sel_cmd;
    logic [87:0] sel_data;
    logic [31:0] sel_cnt;
    logic        sel_invalid;
    logic        unused_data_bits;

    assign valid_vec   = {b_valid, a_valid};
    assign cmd_vec[0]  = a_cmd;
    assign cmd_vec[1]  = b_cmd;
    assign data_vec[0] = a_data;
    assign data_vec[1] = b_data;

    // rr_b_reg set means B is favoured on a tie (A was granted last).
    assign grant_vec[0] = valid_vec[0] & (~valid_vec[1] | ~rr_b_reg);
    assign grant_vec[1] = valid_vec[1] & (~valid_vec[0] | rr_b_reg);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign ready_vec[gi] = (state_reg == ST_IDLE) & grant_vec[gi];
            assign done_vec[gi]  = (state_reg == ST_DONE) & (port_b_reg == (gi != 0));
            assign err_vec[gi]   = done_vec[gi] & err_reg;
        end
    endgenerate

    assign a_ready = ready_vec[0];
    assign b_ready = ready_vec[1];
    assign a_done  = done_vec[0];
    assign b_done  = done_vec[1];
    assign a_err   = err_vec[0];
    assign b_err   = err_vec[1];

    assign sel_b       = grant_vec[1];
    assign accept      = |ready_vec;
    assign sel_cmd     = cmd_vec[sel_b];
    assign sel_data    = data_vec[sel_b];
    assign sel_cnt     = sel_data[71:40];
    assign sel_invalid = (sel_b && sel_cmd == CMD_MODULO) ||
                         (sel_cmd == CMD_ADJ && sel_cnt == CNT_IDLE);
    assign unused_data_bits = ^sel_data[87:86];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_INIT;
            init_ld_reg     <= 1'b0;
            rr_b_reg        <= 1'b0;
            port_b_reg      <= 1'b0;
            cmd_reg         <= CMD_TIME;
            err_reg         <= 1'b0;
            wait_cnt_reg    <= '0;
            modulo_pend_reg <= '0;
            ns_reg          <= '0;
            sec_reg         <= '0;
            period_in_reg   <= PERIOD_DEFAULT;
            adj_data_reg    <= '0;
            period_adj_reg  <= '0;
            modulo_reg      <= MODULO_DEFAULT;
        end else begin
            state_reg       <= state_next;
            init_ld_reg     <= init_ld_next;
            rr_b_reg        <= rr_b_next;
            port_b_reg      <= port_b_next;
            cmd_reg         <= cmd_next;
            err_reg         <= err_next;
            wait_cnt_reg    <= wait_cnt_next;
            modulo_pend_reg <= modulo_pend_next;
            ns_reg          <= ns_next;
            sec_reg         <= sec_next;
            period_in_reg   <= period_in_next;
            adj_data_reg    <= adj_data_next;
            period_adj_reg  <= period_adj_next;
            modulo_reg      <= modulo_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        init_ld_next     = 1'b0;
        rr_b_next        = rr_b_reg;
        port_b_next      = port_b_reg;
        cmd_next         = cmd_reg;
        err_next         = err_reg;
        wait_cnt_next    = wait_cnt_reg;
        modulo_pend_next = modulo_pend_reg;
        ns_next          = ns_reg;
        sec_next         = sec_reg;
        period_in_next   = period_in_reg;
        adj_data_next    = adj_data_reg;
        period_adj_next  = period_adj_reg;
        modulo_next      = modulo_reg;

        case (state_reg)
            // First cycle arms the pulse register, second cycle carries the pulse.
            ST_INIT: begin
                if (!init_ld_reg) begin
                    init_ld_next = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    port_b_next = sel_b;
                    rr_b_next   = ~sel_b;
                    cmd_next    = sel_cmd;
                    err_next    = sel_invalid;
                    if (sel_invalid) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_ISSUE;
                        case (sel_cmd)
                            CMD_TIME: begin
                                ns_next  = sel_data[37:0];
                                sec_next = sel_data[85:38];
                            end
                            CMD_PERIOD: period_in_next = sel_data[39:0];
                            CMD_ADJ: begin
                                adj_data_next   = sel_cnt;
                                period_adj_next = sel_data[39:0];
                            end
                            default: modulo_pend_next = sel_data[37:0];
                        endcase
                    end
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
                case (cmd_reg)
                    CMD_ADJ:    wait_cnt_next = {2'b00, adj_data_reg} + SETTLE;
                    CMD_PERIOD: wait_cnt_next = SETTLE;
                    CMD_MODULO: begin
                        wait_cnt_next = '0;
                        modulo_next   = modulo_pend_reg;
                    end
                    default:    wait_cnt_next = '0;
                endcase
            end
            ST_WAIT: begin
                if (wait_cnt_reg == '0) begin
                    state_next = ST_DONE;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 34'd1;
                end
            end
            ST_DONE: begin
                if (cmd_reg == CMD_ADJ) begin
                    period_adj_next = '0;
                end
                state_next = ST_IDLE;
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign busy            = (state_reg != ST_IDLE);
    assign time_ld         = (state_reg == ST_ISSUE) && (cmd_reg == CMD_TIME);
    assign period_ld       = init_ld_reg || ((state_reg == ST_ISSUE) && (cmd_reg == CMD_PERIOD));
    assign adj_ld          = (state_reg == ST_ISSUE) && (cmd_reg == CMD_ADJ);
    assign time_reg_ns_in  = ns_reg;
    assign time_reg_sec_in = sec_reg;
    assign period_in       = period_in_reg;
    assign adj_ld_data     = adj_data_reg;
    assign period_adj      = period_adj_reg;
    assign time_acc_modulo = modulo_reg;

endmodule

// File: tb/tb_rtc_cmd_ctrl.sv
// Randomised scoreboard bench for rtc_cmd_ctrl: drivers issue commands, a negedge monitor
// checks grants, ld pulses, latencies and responses against a cycle-count reference model.
module tb_rtc_cmd_ctrl;

    localparam logic [39:0] PERIOD_DEF = 40'h08_0000_0000;
    localparam logic [37:0] MOD_DEF    = 38'd256000000000;
    localparam int          SETTLE     = 3;

    logic        clk, rst;
    logic        a_valid, a_ready, a_done, a_err;
    logic        b_valid, b_ready, b_done, b_err;
    logic [1:0]  a_cmd, b_cmd;
    logic [87:0] a_data, b_data;
    logic        busy, time_ld, period_ld, adj_ld;
    logic [37:0] time_reg_ns_in;
    logic [47:0] time_reg_sec_in;
    logic [39:0] period_in, period_adj;
    logic [31:0] adj_ld_data;
    logic [37:0] time_acc_modulo;

    rtc_cmd_ctrl dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_cmd(a_cmd), .a_data(a_data),
        .a_done(a_done), .a_err(a_err),
        .b_valid(b_valid), .b_ready(b_ready), .b_cmd(b_cmd), .b_data(b_data),
        .b_done(b_done), .b_err(b_err),
        .busy(busy),
        .time_ld(time_ld), .time_reg_ns_in(time_reg_ns_in), .time_reg_sec_in(time_reg_sec_in),
        .period_ld(period_ld), .period_in(period_in),
        .adj_ld(adj_ld), .adj_ld_data(adj_ld_data), .period_adj(period_adj),
        .time_acc_modulo(time_acc_modulo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          port_b;
        bit          err;
        int          kind;
        logic [87:0] data;
        longint      ld_cyc;
        longint      done_cyc;
    } exp_t;

    exp_t        exp_q[$];
    bit          grant_log[$];
    int          tests = 0;
    int          fails = 0;
    longint      cyc = 0;
    bit          model_last_b = 1'b1;
    logic [37:0] model_mod = MOD_DEF;
    int          rst_cnt = 0;
    int          init_ctr = 0;
    longint      adj_clear_at = -1;

    task automatic chk(input string name, input logic [87:0] act, input logic [87:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic monitor_step();
        bit   exp_a, exp_b, e_time, e_period, e_adj;
        exp_t e;
        chk("busy", busy, exp_q.size() != 0);
        exp_a = 0;
        exp_b = 0;
        if (exp_q.size() == 0) begin
            exp_a = a_valid && (!b_valid || model_last_b);
            exp_b = b_valid && (!a_valid || !model_last_b);
        end
        chk("a_ready", a_ready, exp_a);
        chk("b_ready", b_ready, exp_b);

        e_time = 0;
        e_period = 0;
        e_adj = 0;
        if (exp_q.size() != 0 && !exp_q[0].err && exp_q[0].ld_cyc == cyc) begin
            e_time   = (exp_q[0].kind == 0);
            e_period = (exp_q[0].kind == 1);
            e_adj    = (exp_q[0].kind == 2);
        end
        chk("time_ld", time_ld, e_time);
        chk("period_ld", period_ld, e_period);
        chk("adj_ld", adj_ld, e_adj);
        if (e_time) begin
            chk("time_ns", time_reg_ns_in, exp_q[0].data[37:0]);
            chk("time_sec", time_reg_sec_in, exp_q[0].data[85:38]);
        end
        if (e_period) chk("period_in", period_in, exp_q[0].data[39:0]);
        if (e_adj) begin
            chk("adj_ld_data", adj_ld_data, exp_q[0].data[71:40]);
            chk("period_adj", period_adj, exp_q[0].data[39:0]);
        end
        if (cyc == adj_clear_at) chk("period_adj_clr", period_adj, 0);

        if (a_done || b_done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got a_done=%0b b_done=%0b, expected none (cycle %0d)",
                         a_done, b_done, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("done_cycle", cyc, e.done_cyc);
                chk("a_done", a_done, !e.port_b);
                chk("b_done", b_done, e.port_b);
                chk("a_err", a_err, !e.port_b && e.err);
                chk("b_err", b_err, e.port_b && e.err);
                chk("modulo", time_acc_modulo, model_mod);
                if (e.kind == 2) adj_clear_at = cyc + 1;
                $display("[TB] txn port=%s cmd=%0d err=%0b done_cycle=%0d",
                         e.port_b ? "B" : "A", e.kind, a_err | b_err, cyc);
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].done_cyc) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done, expected one at cycle %0d", exp_q[0].done_cyc);
            void'(exp_q.pop_front());
        end

        if (a_ready || b_ready) begin
            longint k;
            e.port_b = !a_ready;
            e.kind   = e.port_b ? int'(b_cmd) : int'(a_cmd);
            e.data   = e.port_b ? b_data : a_data;
            e.err    = (e.port_b && e.kind == 3) || (e.kind == 2 && e.data[71:40] == 32'hFFFF_FFFF);
            k = (e.kind == 2) ? longint'(e.data[71:40]) + SETTLE : (e.kind == 1) ? SETTLE : 0;
            e.ld_cyc   = cyc + 1;
            e.done_cyc = e.err ? cyc + 1 : cyc + 3 + k;
            if (!e.err && e.kind == 3) model_mod = e.data[37:0];
            model_last_b = e.port_b;
            grant_log.push_back(e.port_b);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            rst_cnt++;
            exp_q.delete();
            model_last_b = 1'b1;
            model_mod    = MOD_DEF;
            init_ctr     = 0;
            adj_clear_at = -1;
            if (rst_cnt >= 2) begin
                chk("rst_busy", busy, 1);
                chk("rst_handshake", {a_ready, b_ready, a_done, b_done, a_err, b_err}, 0);
                chk("rst_ld", {time_ld, period_ld, adj_ld}, 0);
                chk("rst_period_in", period_in, PERIOD_DEF);
                chk("rst_modulo", time_acc_modulo, MOD_DEF);
                chk("rst_period_adj", period_adj, 0);
                chk("rst_time", {time_reg_sec_in, time_reg_ns_in}, 0);
                chk("rst_adj_data", adj_ld_data, 0);
            end
        end else begin
            if (rst_cnt > 0) begin
                init_ctr = 1;
                rst_cnt  = 0;
            end else if (init_ctr < 3) begin
                init_ctr++;
            end
            if (init_ctr < 3) begin
                chk("init_busy", busy, 1);
                chk("init_period_ld", period_ld, init_ctr == 2);
                if (init_ctr == 2) chk("init_period_in", period_in, PERIOD_DEF);
                chk("init_quiet", {time_ld, adj_ld, a_ready, b_ready, a_done, b_done}, 0);
            end else begin
                monitor_step();
            end
        end
    end

    task automatic send(input bit pb, input logic [1:0] cmd, input logic [87:0] data);
        bit got = 0;
        if (pb) begin
            b_valid = 1; b_cmd = cmd; b_data = data;
        end else begin
            a_valid = 1; a_cmd = cmd; a_data = data;
        end
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            got = pb ? b_ready : a_ready;
            if (got) break;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got no ready on port %s, expected acceptance", pb ? "B" : "A");
        end
        @(posedge clk);
        #1;
        if (pb) b_valid = 0;
        else    a_valid = 0;
    endtask

    task automatic drain();
        bit empty = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                empty = 1;
                break;
            end
        end
        if (!empty) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_cmd(output logic [1:0] cmd, output logic [87:0] data);
        logic [95:0] raw;
        logic [31:0] cnt;
        raw = {$urandom, $urandom, $urandom};
        cmd = 2'($urandom_range(0, 3));
        cnt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 30));
        case (cmd)
            2'd0:    data = {2'b0, raw[85:0]};
            2'd1:    data = {48'b0, raw[39:0]};
            2'd2:    data = {16'b0, cnt, raw[39:0]};
            default: data = {50'b0, raw[37:0]};
        endcase
    endtask

    task automatic rnd_port(input bit pb, input int n);
        logic [1:0]  cmd;
        logic [87:0] data;
        for (int i = 0; i < n; i++) begin
            rnd_cmd(cmd, data);
            send(pb, cmd, data);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0]  ord;
        logic [87:0] d0, d1, d2, d3;
        rst = 1; a_valid = 0; b_valid = 0;
        a_cmd = 0; b_cmd = 0; a_data = 0; b_data = 0;
        repeat (4) @(posedge clk);
        #1 rst = 0;
        repeat (4) @(posedge clk);
        #1;

        send(0, 2'd0, {2'b0, 48'd5, 38'h100});
        drain();
        send(1, 2'd2, {16'b0, 32'd10, 40'h01_0000_0000});
        drain();

        grant_log.delete();
        d0 = {2'b0, 48'd11, 38'h11};
        d1 = {48'b0, 40'h08_1000_0000};
        d2 = {2'b0, 48'd22, 38'h22};
        d3 = {48'b0, 40'h07_F000_0000};
        fork
            begin send(0, 2'd0, d0); send(0, 2'd0, d2); end
            begin send(1, 2'd1, d1); send(1, 2'd1, d3); end
        join
        drain();
        chk("rr_count", grant_log.size(), 4);
        ord = 0;
        for (int i = 0; i < 4 && i < grant_log.size(); i++) ord[i] = grant_log[i];
        chk("rr_order", ord, 4'b1010);

        send(1, 2'd3, {50'b0, 38'h1234});
        drain();
        send(0, 2'd2, {16'b0, 32'hFFFF_FFFF, 40'h5});
        drain();

        fork
            rnd_port(0, 15);
            rnd_port(1, 15);
        join
        drain();

        send(0, 2'd3, {50'b0, 38'h3_0000_1234});
        drain();
        send(1, 2'd2, {16'b0, 32'd1000, 40'h7});
        repeat (20) @(posedge clk);
        #1 rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (1100) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
